// File: rtl/mem_arbiter.sv
// Two-requester burst arbiter onto a single asynchronous word RAM.
// Round-robin grant; one burst of LINE_WORDS beats per grant, one IDLE cycle between bursts.
module mem_arbiter #(
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_wready,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    output logic        r0_done,

    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_wready,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    output logic        r1_done,

    output logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    output logic        mem_ce_n,
    output logic        mem_we_n,
    output logic        mem_oe_n,
    output logic        mem_bw,
    input  logic        mem_hold
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  r_state;
    logic        r_win;      // 0 = r0 owns the burst, 1 = r1
    logic        r_we;
    logic        r_rr;       // last requester served; the other one wins a tie
    logic [3:0]  r_beat;
    logic [31:0] r_addr;
    logic        r_rvalid0, r_rvalid1;
    logic [31:0] r_rdata0, r_rdata1;

    logic        w_access, w_busy, w_beat_ok, w_last, w_pick;
    logic [31:0] w_sel_addr, w_wdata;
    logic        w_unused_ok;

    assign w_access   = (r_state == S_ACCESS);
    assign w_busy     = (r_state == S_ACCESS) || (r_state == S_DONE);
    assign w_beat_ok  = w_access && !mem_hold;
    assign w_last     = (r_beat == 4'(LINE_WORDS - 1));
    assign w_pick     = (r0_req && r1_req) ? ~r_rr : r1_req;
    assign w_sel_addr = w_pick ? r1_addr : r0_addr;
    assign w_wdata    = r_win ? r1_wdata : r0_wdata;
    assign w_unused_ok = ^{r0_addr[1:0], r1_addr[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_rr    <= 1'b1;
            r_beat  <= 4'd0;
            r_addr  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r0_req || r1_req) begin
                        r_state <= S_ACCESS;
                        r_win   <= w_pick;
                        r_we    <= w_pick ? r1_we : r0_we;
                        r_addr  <= {w_sel_addr[31:2], 2'b00};
                        r_beat  <= 4'd0;
                    end
                end
                S_ACCESS: begin
                    if (!mem_hold) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_beat <= r_beat + 4'd1;
                            r_addr <= r_addr + 32'd4;
                        end
                    end
                end
                S_DONE: begin
                    r_rr    <= r_win;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read beats are captured from the bus at the edge that completes them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= 32'd0;
            r_rdata1  <= 32'd0;
        end else begin
            r_rvalid0 <= w_beat_ok && !r_we && !r_win;
            r_rvalid1 <= w_beat_ok && !r_we &&  r_win;
            if (w_beat_ok && !r_we && !r_win) r_rdata0 <= mem_data;
            if (w_beat_ok && !r_we &&  r_win) r_rdata1 <= mem_data;
        end
    end

    assign r0_gnt    = w_busy && !r_win;
    assign r1_gnt    = w_busy &&  r_win;
    assign r0_wready = w_beat_ok && r_we && !r_win;
    assign r1_wready = w_beat_ok && r_we &&  r_win;
    assign r0_done   = (r_state == S_DONE) && !r_win;
    assign r1_done   = (r_state == S_DONE) &&  r_win;
    assign r0_rvalid = r_rvalid0;
    assign r1_rvalid = r_rvalid1;
    assign r0_rdata  = r_rdata0;
    assign r1_rdata  = r_rdata1;

    assign mem_addr = r_addr;
    assign mem_ce_n = ~w_access;
    assign mem_we_n = ~(w_access &&  r_we);
    assign mem_oe_n = ~(w_access && !r_we);
    assign mem_bw   = 1'b1;
    assign mem_data = (w_access && r_we) ? w_wdata : {32{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: word RAM model, bus monitor, hand-computed expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [31:0] r0_addr = 32'd0, r0_wdata = 32'd0;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0;
    logic        mem_hold = 1'b0;
    logic        r0_gnt, r0_wready, r0_rvalid, r0_done;
    logic        r1_gnt, r1_wready, r1_rvalid, r1_done;
    logic [31:0] r0_rdata, r1_rdata, mem_addr;
    logic        mem_ce_n, mem_we_n, mem_oe_n, mem_bw;
    wire  [31:0] mem_data;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_WORDS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_wready(r0_wready), .r0_rvalid(r0_rvalid),
        .r0_rdata(r0_rdata), .r0_done(r0_done),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_wready(r1_wready), .r1_rvalid(r1_rvalid),
        .r1_rdata(r1_rdata), .r1_done(r1_done),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ce_n(mem_ce_n), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n),
        .mem_bw(mem_bw), .mem_hold(mem_hold)
    );

    // RAM: 64 words, word i preloaded with A000_0000+i
    logic [31:0] ram [64];
    bit          ram_ok;
    always @(posedge clk) begin
        if (!ram_ok) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'hA000_0000 + i;
            ram_ok <= 1'b1;
        end else if (!mem_ce_n && !mem_we_n && !mem_hold) begin
            ram[mem_addr[7:2]] <= mem_data;
        end
    end
    assign mem_data = (!mem_ce_n && !mem_oe_n) ? ram[mem_addr[7:2]] : {32{1'bz}};

    // Monitor
    int          cyc;
    logic [31:0] addr_q[$], rd0_q[$], rd1_q[$];
    int          gnt_q[$];
    int          done0_n, done1_n, wr1_n, hold4_n, bus_err, last_beat_cyc, done0_cyc;
    logic        pg0, pg1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!mem_ce_n && !mem_hold) begin
            addr_q.push_back(mem_addr);
            last_beat_cyc <= cyc;
        end
        if (r0_rvalid) rd0_q.push_back(r0_rdata);
        if (r1_rvalid) rd1_q.push_back(r1_rdata);
        if (r0_done) begin done0_n <= done0_n + 1; done0_cyc <= cyc; end
        if (r1_done) done1_n <= done1_n + 1;
        if (r1_wready) wr1_n <= wr1_n + 1;
        if (!mem_ce_n && !mem_we_n && mem_addr == 32'h1001_0004) hold4_n <= hold4_n + 1;
        if (r0_gnt && !pg0) gnt_q.push_back(0);
        if (r1_gnt && !pg1) gnt_q.push_back(1);
        pg0 <= r0_gnt;
        pg1 <= r1_gnt;
        if ((!mem_oe_n && !mem_we_n) || (r0_gnt && r1_gnt) ||
            (mem_ce_n && (!mem_we_n || !mem_oe_n)))
            bus_err <= bus_err + 1;
    end

    int n_cmp, n_bad;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One requester runs a whole burst; hold_beat >= 0 stalls that beat for 3 cycles.
    task automatic run_burst(input int who, input bit we, input logic [31:0] addr,
                             input logic [31:0] wbase, input int hold_beat);
        bit          adv = 1'b0, fin = 1'b0;
        int          hl = 3;
        logic [31:0] wd = wbase;
        logic [31:0] haddr = {addr[31:2], 2'b00} + 32'(4 * hold_beat);
        if (who == 0) begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wd; end
        else          begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wd; end
        for (int c = 0; c < 100 && !fin; c++) begin
            @(posedge clk); #1;
            if (adv) begin
                wd = wd + 1;
                if (who == 0) r0_wdata = wd; else r1_wdata = wd;
            end
            mem_hold = 1'b0;
            if (hold_beat >= 0 && hl > 0 && (r0_gnt || r1_gnt) && !mem_ce_n && mem_addr == haddr) begin
                mem_hold = 1'b1;
                hl--;
            end
            #1;
            adv = (who == 0) ? r0_wready : r1_wready;
            if ((who == 0) ? r0_done : r1_done) begin
                fin = 1'b1;
                if (who == 0) r0_req = 0; else r1_req = 0;
            end
        end
        mem_hold = 1'b0;
        chk("burst_timeout", 32'(fin), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0i, r1i, g0, d1;
        bit got;
        logic [31:0] exp_wrap [4];
        exp_wrap[0] = 32'hFFFF_FFF8; exp_wrap[1] = 32'hFFFF_FFFC;
        exp_wrap[2] = 32'h0000_0000; exp_wrap[3] = 32'h0000_0004;

        // Reset state
        #2;
        chk("rst_gnt0", 32'(r0_gnt), 0);
        chk("rst_gnt1", 32'(r1_gnt), 0);
        chk("rst_rvalid0", 32'(r0_rvalid), 0);
        chk("rst_rdata0", r0_rdata, 0);
        chk("rst_done0", 32'(r0_done), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_strobes", {29'd0, mem_ce_n, mem_we_n, mem_oe_n}, 32'd7);
        chk("rst_bw", 32'(mem_bw), 1);
        @(posedge clk); #1; reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Single read burst from r0
        a0 = addr_q.size(); r0i = rd0_q.size();
        run_burst(0, 1'b0, 32'h1001_0003, 32'd0, -1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rd_addr%0d", k), addr_q[a0 + k], 32'h1001_0000 + 32'(4 * k));
            chk($sformatf("rd_data%0d", k), rd0_q[r0i + k], 32'hA000_0000 + 32'(k));
        end
        chk("rd_beats", 32'(rd0_q.size() - r0i), 4);
        chk("rd_done_lat", 32'(done0_cyc - last_beat_cyc), 1);
        chk("idle_addr_hold", mem_addr, 32'h1001_000C);

        // Address wrap
        a0 = addr_q.size(); r0i = rd0_q.size();
        run_burst(0, 1'b0, 32'hFFFF_FFF8, 32'd0, -1);
        for (int k = 0; k < 4; k++) chk($sformatf("wrap_addr%0d", k), addr_q[a0 + k], exp_wrap[k]);
        chk("wrap_data2", rd0_q[r0i + 2], 32'hA000_0000);
        chk("wrap_data1", rd0_q[r0i + 1], 32'hA000_003F);

        // Write from r1 with a 3-cycle stall on beat 1, then read back
        g0 = wr1_n; d1 = hold4_n;
        run_burst(1, 1'b1, 32'h1001_0000, 32'hC0DE_0000, 1);
        chk("wr_wready", 32'(wr1_n - g0), 4);
        chk("wr_hold_cycles", 32'(hold4_n - d1), 4);
        r1i = rd1_q.size();
        run_burst(1, 1'b0, 32'h1001_0000, 32'd0, -1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("readback%0d", k), rd1_q[r1i + k], 32'hC0DE_0000 + 32'(k));

        // Contention after reset: r0, r1, r0, r1
        reset_n = 1'b0; @(posedge clk); #1; reset_n = 1'b1;
        g0 = gnt_q.size();
        r0_we = 0; r0_addr = 32'h1001_0000; r1_we = 0; r1_addr = 32'h1001_0040;
        r0_req = 1; r1_req = 1;
        for (int c = 0; c < 80 && gnt_q.size() < g0 + 4; c++) begin @(posedge clk); #1; end
        r0_req = 0; r1_req = 0;
        chk("cont_count", 32'(gnt_q.size() >= g0 + 4), 1);
        if (gnt_q.size() >= g0 + 4)
            for (int k = 0; k < 4; k++) chk($sformatf("cont_gnt%0d", k), 32'(gnt_q[g0 + k]), 32'(k % 2));
        repeat (10) @(posedge clk); #1;

        // Reset during beat 2 of an r1 write
        r1_we = 1; r1_addr = 32'h1001_0020; r1_wdata = 32'h5555_0000; r1_req = 1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            if (r1_gnt && mem_addr == 32'h1001_0028) got = 1;
        end
        chk("rst_mid_reach", 32'(got), 1);
        d1 = done1_n;
        reset_n = 1'b0; #1;
        chk("rst_mid_strobes", {29'd0, mem_ce_n, mem_we_n, mem_oe_n}, 32'd7);
        chk("rst_mid_gnt1", 32'(r1_gnt), 0);
        chk("rst_mid_wready", 32'(r1_wready), 0);
        chk("rst_mid_addr", mem_addr, 0);
        r0_we = 0; r0_addr = 32'h1001_0000; r0_req = 1;
        g0 = gnt_q.size();
        @(posedge clk); #1; reset_n = 1'b1;
        for (int c = 0; c < 10 && gnt_q.size() == g0; c++) begin @(posedge clk); #1; end
        chk("rst_mid_first_gnt", (gnt_q.size() > g0) ? 32'(gnt_q[g0]) : 32'hFFFF_FFFF, 0);
        chk("rst_mid_no_done", 32'(done1_n - d1), 0);
        for (int c = 0; c < 60 && (r0_req || r1_req); c++) begin
            @(posedge clk); #1;
            if (r0_done) r0_req = 0;
            if (r1_done) r1_req = 0;
        end
        chk("rst_mid_drain", 32'(r0_req || r1_req), 0);
        repeat (3) @(posedge clk); #1;

        chk("bus_rules", 32'(bus_err), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per burst (cache line); legal range 1..16.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports rN_req  input  1, N in {0,1}: requester N requests a burst; held high until rN_done.
REQ-005 SHALL have ports rN_we  input  1: burst direction, 1 = write, 0 = read; sampled with the grant.
REQ-006 SHALL have ports rN_addr  input  32: burst base byte address; sampled with the grant; bits [1:0] ignored.
REQ-007 SHALL have ports rN_wdata  input  32: write data for the current beat.
REQ-008 SHALL have ports rN_gnt  output  1: requester N owns the memory.
REQ-009 SHALL have ports rN_wready  output  1: current write beat accepted this cycle; requester advances wdata.
REQ-010 SHALL have ports rN_rvalid  output  1 and rN_rdata  output  32: one registered read beat.
REQ-011 SHALL have ports rN_done  output  1: one-cycle pulse at burst end.
REQ-012 SHALL have port mem_addr  output  32: byte address to the RAM.
REQ-013 SHALL have port mem_data  inout  32: shared RAM data bus.
REQ-014 SHALL have ports mem_ce_n, mem_we_n, mem_oe_n, mem_bw  output  1 each: RAM strobes; mem_bw = 1 selects word access.
REQ-015 SHALL have port mem_hold  input  1: RAM busy; no beat completes while high.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-017 IDLE: with any rN_req high at a clock edge, the FSM SHALL move to ACCESS; it SHALL latch the winner, its we, and {addr[31:2],2'b00}; it SHALL clear beat count to 0.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; after reset, r0 wins.
REQ-019 rN_gnt SHALL be high for the winner from ACCESS entry through the DONE cycle inclusive; at most one gnt is high.
REQ-020 ACCESS: mem_ce_n=0, mem_bw=1, mem_addr = base + 4*beat, 32-bit modulo wrap (0xFFFFFFFC + 4 -> 0x00000000).
REQ-021 ACCESS read: mem_oe_n=0 and mem_we_n=1; the block SHALL NOT drive mem_data.
REQ-022 ACCESS write: mem_we_n=0 and mem_oe_n=1; mem_data SHALL be driven with the winner's rN_wdata.
REQ-023 mem_data SHALL be high-Z in every cycle except ACCESS write.
REQ-024 mem_oe_n and mem_we_n SHALL never be low in the same cycle.
REQ-025 A beat SHALL complete in an ACCESS cycle with mem_hold=0; with mem_hold=1, address, strobes and beat count SHALL hold.
REQ-026 Read beat completion: at the next edge, rN_rdata <= mem_data and rN_rvalid = 1 for exactly one cycle.
REQ-027 Write beat completion: rN_wready SHALL be high combinationally in that same cycle only.
REQ-028 On completion of beat LINE_WORDS-1, the FSM SHALL go to DONE; otherwise the beat count SHALL increment.
REQ-029 DONE: strobes deasserted (all 1), rN_done=1 for one cycle, rr pointer set to the winner; next state IDLE.
REQ-030 rN_req deasserting mid-burst SHALL be ignored; the burst runs to completion.
REQ-031 A request arriving while busy SHALL wait; at least one IDLE cycle separates bursts.
REQ-032 Outside ACCESS: mem_ce_n=mem_we_n=mem_oe_n=1, mem_bw=1, mem_addr holds its last value.

Reset
REQ-033 reset_n low SHALL immediately force: FSM IDLE, all gnt/wready/rvalid/done = 0, rdata = 0, mem_addr = 0, strobes = 1, mem_bw=1, mem_data high-Z, rr favouring r0; an in-flight burst SHALL be abandoned.

Verification
REQ-034 Single read, LINE_WORDS=4, mem_hold=0, r0 addr 0x10010000 -> mem_addr steps 0x10010000..0x1001000C; four r0_rvalid pulses carry RAM words 0..3; r0_done one cycle after the last beat.
REQ-035 Contention: r0, r1 both requesting reads continuously -> grants alternate r0, r1, r0, r1; never two gnt high.
REQ-036 Write with mem_hold high 3 cycles on beat 1 -> mem_addr 0x10010004 held for 4 cycles; r1_wready pulses once per beat (4 total); data read back equals written.
REQ-037 Address wrap: base 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-038 Reset pulse during beat 2 of a write -> strobes = 1, mem_data Z, no done pulse; after release, pending r1 and r0 -> r0 granted first.
REQ-039 Bus check every cycle: mem_data driven only when mem_we_n=0; oe_n and we_n never both 0.
